// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
// Module   : register_bank
// Purpose  : NUM_REGS x WIDTH register file with shared 3-bit function select,
//            per-register enables and wrap flags, and two combinational read ports.
//            Optional macro REGBANK_SAT_ARITH_EN makes increment/decrement saturate.
// Revision : 1.0 - initial release
// ============================================================================
module register_bank #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 4,
  localparam int SW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                Clock,
  input  logic                rst,
  input  logic [NUM_REGS-1:0] E,
  input  logic [2:0]          FunSel,
  input  logic [WIDTH-1:0]    I,
  input  logic [SW-1:0]       RdSelA,
  input  logic [SW-1:0]       RdSelB,
  output logic [WIDTH-1:0]    QA,
  output logic [WIDTH-1:0]    QB,
  output logic [NUM_REGS-1:0] Wrap
);

  localparam int c_H = WIDTH / 2;

  localparam logic [2:0] c_OP_DEC    = 3'b000;
  localparam logic [2:0] c_OP_INC    = 3'b001;
  localparam logic [2:0] c_OP_LOAD   = 3'b010;
  localparam logic [2:0] c_OP_CLR    = 3'b011;
  localparam logic [2:0] c_OP_LO_ZX  = 3'b100;
  localparam logic [2:0] c_OP_LO_KP  = 3'b101;
  localparam logic [2:0] c_OP_LO2HI  = 3'b110;
  localparam logic [2:0] c_OP_LO_SX  = 3'b111;

  localparam logic [WIDTH-1:0] c_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [c_H-1:0]   c_HZERO = {c_H{1'b0}};

  logic [WIDTH-1:0] w_q [NUM_REGS];
  logic [c_H-1:0]   w_i_lo;
  logic [c_H-1:0]   w_i_sign;
  logic             w_is_inc;
  logic             w_is_dec;

  assign w_i_lo   = I[c_H-1:0];
  assign w_i_sign = {c_H{I[c_H-1]}};
  assign w_is_inc = (FunSel == c_OP_INC);
  assign w_is_dec = (FunSel == c_OP_DEC);

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      logic [WIDTH-1:0] r_q;
      logic             r_wrap;
      logic [WIDTH-1:0] w_q_next;
      logic [WIDTH-1:0] w_inc;
      logic [WIDTH-1:0] w_dec;
      logic             w_at_ones;
      logic             w_at_zero;
      logic             w_wrap;

      assign w_at_ones = (r_q == c_ONES);
      assign w_at_zero = (r_q == c_ZERO);

`ifdef REGBANK_SAT_ARITH_EN
      // Saturating build: the wrap attempt leaves the register untouched.
      assign w_inc = w_at_ones ? r_q : r_q + c_ONE;
      assign w_dec = w_at_zero ? r_q : r_q - c_ONE;
`else
      assign w_inc = r_q + c_ONE;
      assign w_dec = r_q - c_ONE;
`endif

      always_comb begin
        w_q_next = r_q;
        if (E[g]) begin
          case (FunSel)
            c_OP_DEC:   w_q_next = w_dec;
            c_OP_INC:   w_q_next = w_inc;
            c_OP_LOAD:  w_q_next = I;
            c_OP_CLR:   w_q_next = c_ZERO;
            c_OP_LO_ZX: w_q_next = {c_HZERO, w_i_lo};
            c_OP_LO_KP: w_q_next = {r_q[WIDTH-1:c_H], w_i_lo};
            c_OP_LO2HI: w_q_next = {w_i_lo, r_q[c_H-1:0]};
            c_OP_LO_SX: w_q_next = {w_i_sign, w_i_lo};
            default:    w_q_next = r_q;
          endcase
        end
      end

      // Wrap is recomputed every edge, so it behaves as a per-event pulse.
      assign w_wrap = E[g] & ((w_is_inc & w_at_ones) | (w_is_dec & w_at_zero));

      always_ff @(posedge Clock or negedge rst) begin
        if (!rst) begin
          r_q    <= c_ZERO;
          r_wrap <= 1'b0;
        end else begin
          r_q    <= w_q_next;
          r_wrap <= w_wrap;
        end
      end

      assign w_q[g]  = r_q;
      assign Wrap[g] = r_wrap;
    end
  endgenerate

  // Out-of-range selects match no entry and therefore read as zero.
  always_comb begin
    QA = c_ZERO;
    QB = c_ZERO;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (RdSelA == SW'(k)) QA = w_q[k];
      if (RdSelB == SW'(k)) QB = w_q[k];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_bank
// Purpose  : Scoreboard bench for register_bank (4-entry bank plus a 3-entry
//            instance for out-of-range read selects).
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_bank;

  logic        Clock;
  logic        rst;
  logic [3:0]  E;
  logic [2:0]  FunSel;
  logic [15:0] I;
  logic [1:0]  RdSelA;
  logic [1:0]  RdSelB;
  logic [15:0] QA;
  logic [15:0] QB;
  logic [3:0]  Wrap;

  logic [2:0]  E3;
  logic [1:0]  RdSelA3;
  logic [1:0]  RdSelB3;
  logic [15:0] QA3;
  logic [15:0] QB3;
  logic [2:0]  Wrap3;

  typedef struct {
    string       tag;
    int          idx;
    logic [15:0] val;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] m [4];
  logic [3:0]  mw;
  int          n_vec = 0;
  int          n_err = 0;

  register_bank #(.WIDTH(16), .NUM_REGS(4)) u_dut (
    .Clock(Clock), .rst(rst), .E(E), .FunSel(FunSel), .I(I),
    .RdSelA(RdSelA), .RdSelB(RdSelB), .QA(QA), .QB(QB), .Wrap(Wrap)
  );

  register_bank #(.WIDTH(16), .NUM_REGS(3)) u_dut3 (
    .Clock(Clock), .rst(rst), .E(E3), .FunSel(FunSel), .I(I),
    .RdSelA(RdSelA3), .RdSelB(RdSelB3), .QA(QA3), .QB(QB3), .Wrap(Wrap3)
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour: returns {wrap, next value}.
  function automatic logic [16:0] mdl(input logic [15:0] q, input logic [2:0] fs,
                                      input logic [15:0] d);
    logic        w;
    logic [15:0] v;
    w = ((fs == 3'b001) && (q == 16'hFFFF)) || ((fs == 3'b000) && (q == 16'h0000));
    case (fs)
      3'b000:  v = q - 16'd1;
      3'b001:  v = q + 16'd1;
      3'b010:  v = d;
      3'b011:  v = 16'h0000;
      3'b100:  v = {8'h00, d[7:0]};
      3'b101:  v = {q[15:8], d[7:0]};
      3'b110:  v = {d[7:0], q[7:0]};
      default: v = {{8{d[7]}}, d[7:0]};
    endcase
`ifdef REGBANK_SAT_ARITH_EN
    if (w) v = q;
`endif
    return {w, v};
  endfunction

  task automatic drain(input string nm);
    exp_t x;
    int   nb;
    while (sbq.size() != 0) begin
      x  = sbq.pop_front();
      nb = (x.idx + 1) % 4;
      RdSelA = 2'(x.idx);
      RdSelB = 2'(nb);
      #1;
      chk(x.tag, 32'(QA), 32'(x.val));
      chk({x.tag, ".B"}, 32'(QB), 32'(m[nb]));
    end
    chk({nm, ".wrap"}, 32'(Wrap), 32'(mw));
  endtask

  task automatic do_op(input logic [3:0] e, input logic [2:0] fs,
                       input logic [15:0] d, input string nm);
    logic [16:0] r;
    @(negedge Clock);
    E = e; FunSel = fs; I = d;
    for (int i = 0; i < 4; i++) begin
      if (e[i]) begin
        r     = mdl(m[i], fs, d);
        m[i]  = r[15:0];
        mw[i] = r[16];
      end else begin
        mw[i] = 1'b0;
      end
      sbq.push_back('{tag: $sformatf("%s.r%0d", nm, i), idx: i, val: m[i]});
    end
    @(posedge Clock);
    #1;
    E = 4'b0000;
    drain(nm);
  endtask

  initial begin
    rst = 1'b0; E = '0; FunSel = 3'b010; I = '0;
    RdSelA = 2'd0; RdSelB = 2'd1;
    E3 = '0; RdSelA3 = 2'd2; RdSelB3 = 2'd3;
    for (int i = 0; i < 4; i++) m[i] = 16'h0000;
    mw = 4'b0000;

    #3;
    chk("rst.QA", 32'(QA), 32'h0);
    chk("rst.QB", 32'(QB), 32'h0);
    chk("rst.Wrap", 32'(Wrap), 32'h0);
    chk("rst.QA3", 32'(QA3), 32'h0);
    @(negedge Clock);
    rst = 1'b1;

    do_op(4'b0000, 3'b001, 16'h0000, "hold_after_rst");

    do_op(4'b0001, 3'b010, 16'hBEEF, "ld0");
    do_op(4'b0010, 3'b010, 16'h00FF, "ld1");
    RdSelA = 2'd1; RdSelB = 2'd1;
    #1;
    chk("same_sel.A", 32'(QA), 32'(m[1]));
    chk("same_sel.B", 32'(QB), 32'(m[1]));

    do_op(4'b0001, 3'b101, 16'h1280, "fs101");
    do_op(4'b0001, 3'b110, 16'h0034, "fs110");
    do_op(4'b0001, 3'b111, 16'h0080, "fs111");
    do_op(4'b0001, 3'b100, 16'hAB80, "fs100");
    do_op(4'b0001, 3'b111, 16'h1234, "fs111_pos");

    do_op(4'b0100, 3'b010, 16'hFFFF, "ld2");
    do_op(4'b0100, 3'b001, 16'h0000, "inc_wrap");
    do_op(4'b0000, 3'b010, 16'h0000, "idle");
    do_op(4'b0100, 3'b011, 16'h0000, "clr2");
    do_op(4'b0100, 3'b000, 16'h0000, "dec_wrap");
    do_op(4'b0100, 3'b001, 16'h0000, "inc_again");

    do_op(4'b0001, 3'b010, 16'h0000, "mld0");
    do_op(4'b0010, 3'b010, 16'h0005, "mld1");
    do_op(4'b0100, 3'b010, 16'hFFFF, "mld2");
    do_op(4'b1000, 3'b010, 16'h0007, "mld3");
    do_op(4'b1111, 3'b001, 16'h0000, "multi_inc");
    do_op(4'b1111, 3'b000, 16'h0000, "multi_dec");
    do_op(4'b0110, 3'b011, 16'h0000, "clr_mid");

    do_op(4'b0010, 3'b010, 16'h1234, "ld1234");
    #2;
    rst = 1'b0;
    #1;
    RdSelA = 2'd1; RdSelB = 2'd0;
    #1;
    chk("async_rst.QA", 32'(QA), 32'h0);
    chk("async_rst.QB", 32'(QB), 32'h0);
    chk("async_rst.Wrap", 32'(Wrap), 32'h0);
    for (int i = 0; i < 4; i++) m[i] = 16'h0000;
    mw = 4'b0000;
    @(negedge Clock);
    rst = 1'b1;
    do_op(4'b0000, 3'b001, 16'h0000, "post_rst_hold");

    @(negedge Clock);
    E3 = 3'b100; FunSel = 3'b010; I = 16'hA5A5;
    @(posedge Clock);
    #1;
    E3 = 3'b000;
    RdSelA3 = 2'd2; RdSelB3 = 2'd3;
    #1;
    chk("n3.sel2", 32'(QA3), 32'hA5A5);
    chk("n3.selB3", 32'(QB3), 32'h0);
    RdSelA3 = 2'd3;
    #1;
    chk("n3.selA3", 32'(QA3), 32'h0);
    chk("n3.wrap", 32'(Wrap3), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
